// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with 3-FF resync, parity and stop-bit checking
module uart_rx_oversampled #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        rx_busy
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = INPUT_DATA_WIDTH > 1 ? $clog2(INPUT_DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam bit ODD = PARITY_TYPE != 0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                      state;
    logic [2:0]                  sync;
    logic                        rx_s;
    logic [CNT_W-1:0]            sample_cnt;
    logic [IDX_W-1:0]            bit_idx;
    logic [INPUT_DATA_WIDTH-1:0] shreg;
    logic                        par;
    logic                        par_err;

    assign rx_s = sync[2];

    // Three-flop resynchroniser; resets to idle-high so reset never fakes a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync <= '1;
        else
            sync <= {sync[1:0], serial_in};
    end

    // Frame FSM: mid-bit sampling, LSB-first deserialisation, parity/stop check, strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            par           <= 1'b0;
            par_err       <= 1'b0;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            data_is_valid <= 1'b0;
            sample_cnt    <= sample_cnt + 1'b1;
            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: if (sample_cnt == HALF) begin
                    sample_cnt <= '0;
                    bit_idx    <= '0;
                    par        <= 1'b0;
                    par_err    <= 1'b0;
                    state      <= rx_s ? IDLE : DATA;
                    rx_busy    <= !rx_s;
                end
                DATA: if (sample_cnt == LAST) begin
                    sample_cnt <= '0;
                    shreg      <= {rx_s, shreg[INPUT_DATA_WIDTH-1:1]};
                    par        <= par ^ rx_s;
                    bit_idx    <= bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT)
                        state <= PARITY_ENABLED != 0 ? PARITY : STOP;
                end
                PARITY: if (sample_cnt == LAST) begin
                    sample_cnt <= '0;
                    par_err    <= par ^ rx_s ^ ODD;
                    state      <= STOP;
                end
                STOP: if (sample_cnt == LAST) begin
                    sample_cnt    <= '0;
                    received_data <= shreg;
                    data_is_valid <= 1'b1;
                    rx_error      <= par_err | !rx_s;
                    state         <= rx_s ? IDLE : BREAK;
                    rx_busy       <= !rx_s;
                end
                BREAK: begin
                    sample_cnt <= '0;
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
